mul8_accum: RTL and testbench
=============================

Name: mul8_accum

Overview:
Downstream stage of the 8-bit pipelined multiplier. Consumes its product stream (8-bit product + valid, no backpressure) and sums every LEN consecutive valid products into one ACC_W-bit dot-product result. Completed results are buffered in a small FIFO and presented on a valid/ready output handshake, so slow consumers do not stall the multiplier.

Parameters:
LEN, 8, products per frame (>=2)
ACC_W, 16, accumulator/result width; must be >= 8+clog2(LEN), so no wrap is possible
DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
valid_i  input  1  product beat valid (from multiplier valid_o)
p_i  input  8  product value (from multiplier p_o)
clr_i  input  1  abort current partial frame
sum_o  output  ACC_W  FIFO head result; 0 when FIFO empty
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts sum_o
level_o  output  clog2(DEPTH)+1  FIFO occupancy
busy_o  output  1  partial frame in progress (cnt != 0)
overflow_o  output  1  sticky: a completed result was dropped

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named rst. During rst: all state cleared next edge; sum_o=0, valid_o=0, level_o=0, busy_o=0, overflow_o=0, beat counter=0, accumulator=0, FIFO empty. Reset mid-frame discards the partial sum. Reset with a non-empty FIFO discards all buffered results.
- FSM: IDLE (cnt==0) and ACC (0<cnt<LEN).
  - IDLE + valid_i: acc<=p_i (zero-extended), cnt<=1, go to ACC.
  - ACC + valid_i, cnt<LEN-1: acc<=acc+p_i, cnt++.
  - ACC + valid_i, cnt==LEN-1: result=acc+p_i is pushed to the FIFO at the same edge; cnt<=0, go to IDLE.
  - valid_i low: hold all state. Gaps between beats of any length are allowed.
- clr_i has priority over valid_i. At the edge: cnt<=0, acc<=0, the same-cycle beat is discarded, and the FIFO is unaffected.
- Latency: valid_o rises in the cycle immediately after the edge that sampled the final beat of a frame. With ready_i=1 and an empty FIFO, that result is popped at the next edge.
- Pop occurs when valid_o&&ready_i at an edge. sum_o/valid_o are driven from the FIFO head register and path; no combinational path exists from ready_i to valid_o.
- Push while full:
  - Accepted if a pop occurs at the same edge; level is unchanged.
  - Otherwise the result is dropped, overflow_o<=1 (cleared only by rst), and the FIFO contents are unchanged.
- Simultaneous push and pop on an empty FIFO cannot occur, because valid_o=0.
- FIFO pointers wrap modulo DEPTH. level_o counts 0..DEPTH.
- All outputs are registered or derived from registered state only.

Optional Feature:
Macro MUL8_ACC_FRAME_ID_EN.
- Defined: adds output frame_id_o [7:0] and stores an 8-bit frame counter alongside each FIFO entry. frame_id_o shows the head entry's id, or 0 when empty. The counter resets to 0 and increments per completed frame, including dropped ones, wrapping 255->0. clr_i-aborted frames do not increment it.
- Undefined: no port and no counter logic.

Test Plan:
LEN=4, ACC_W=16, DEPTH=4.
1. ready_i=1; beats 1,2,3,4 back-to-back -> valid_o high exactly one cycle, the cycle after the 4th beat edge; sum_o=10; level_o returns to 0.
2. Beats 255,255,255,255 -> sum_o=1020 (0x03FC); no wrap.
3. ready_i=0; 5 frames of 1,1,1,1 -> level_o=4, fifth result dropped, overflow_o=1. Then ready_i=1 -> four pops of 4, valid_o=0, overflow_o stays 1.
4. Gapped beats 5,idle,idle,6,7,idle,8 -> busy_o high from after beat 1 until the final edge; sum_o=26.
5. Beats 10,20, then clr_i with a concurrent beat 99, then 1,1,1,1 -> single result 4; busy_o=0 after the clr_i edge. With MUL8_ACC_FRAME_ID_EN: id 0.
6. FIFO holding 2 results plus a 2-beat partial frame; assert rst 1 cycle -> next cycle valid_o=0, level_o=0, busy_o=0, overflow_o=0. The following frame 2,2,2,2 -> sum_o=8.

Source files
------------

// File: rtl/mul8_accum_if.sv
// mul8_accum_if: product stream in, buffered dot-product results out.
// Macro MUL8_ACC_FRAME_ID_EN adds frame_id_o.
interface mul8_accum_if #(
    parameter int ACC_W = 16,
    parameter int DEPTH = 4
);
    logic                     valid_i;
    logic [7:0]               p_i;
    logic                     clr_i;
    logic [ACC_W-1:0]         sum_o;
    logic                     valid_o;
    logic                     ready_i;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     busy_o;
    logic                     overflow_o;
`ifdef MUL8_ACC_FRAME_ID_EN
    logic [7:0]               frame_id_o;
    modport master (
        output valid_i, p_i, clr_i, ready_i,
        input  sum_o, valid_o, level_o, busy_o, overflow_o, frame_id_o
    );
    modport slave (
        input  valid_i, p_i, clr_i, ready_i,
        output sum_o, valid_o, level_o, busy_o, overflow_o, frame_id_o
    );
`else
    modport master (
        output valid_i, p_i, clr_i, ready_i,
        input  sum_o, valid_o, level_o, busy_o, overflow_o
    );
    modport slave (
        input  valid_i, p_i, clr_i, ready_i,
        output sum_o, valid_o, level_o, busy_o, overflow_o
    );
`endif
endinterface

// File: rtl/mul8_accum.sv
// mul8_accum: sums every LEN valid products into one result, buffered in a DEPTH-entry FIFO.
// Macro MUL8_ACC_FRAME_ID_EN tags each result with an 8-bit frame counter.
module mul8_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 16,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    mul8_accum_if.slave bus
);
    localparam int CW = $clog2(LEN);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);
    typedef enum logic {IDLE, ACC} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] mem_q [DEPTH];
    logic [ACC_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [ACC_W-1:0] p_ext;
    logic             empty, full, pop, done, push;
`ifdef MUL8_ACC_FRAME_ID_EN
    logic [7:0]       fid_q, fid_d;
    logic [7:0]       id_mem_q [DEPTH];
    logic [7:0]       id_mem_d [DEPTH];
`endif
    always_comb begin
        p_ext = ACC_W'(bus.p_i);
        empty = level_q == '0;
        full  = level_q == FULL_LVL;
        pop   = !empty && bus.ready_i;
        done  = bus.valid_i && !bus.clr_i && state_q == ACC && cnt_q == LAST_CNT;
        // a full FIFO still accepts when the head leaves on the same edge
        push  = done && (!full || pop);
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (bus.clr_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (bus.valid_i) begin
            if (state_q == IDLE) begin
                state_d = ACC;
                cnt_d   = CW'(1);
                acc_d   = p_ext;
            end else if (done) begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                acc_d   = acc_q + p_ext;
            end
        end
    end
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        overflow_d = overflow_q || (done && !push);
        if (push) mem_d[wr_ptr_q] = acc_q + p_ext;
    end
`ifdef MUL8_ACC_FRAME_ID_EN
    always_comb begin
        id_mem_d = id_mem_q;
        fid_d    = done ? fid_q + 8'd1 : fid_q;
        if (push) id_mem_d[wr_ptr_q] = fid_q;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
`ifdef MUL8_ACC_FRAME_ID_EN
            fid_q      <= '0;
            id_mem_q   <= '{default: '0};
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
`ifdef MUL8_ACC_FRAME_ID_EN
            fid_q      <= fid_d;
            id_mem_q   <= id_mem_d;
`endif
        end
    end
    assign bus.sum_o      = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.valid_o    = !empty;
    assign bus.level_o    = level_q;
    assign bus.busy_o     = state_q == ACC;
    assign bus.overflow_o = overflow_q;
`ifdef MUL8_ACC_FRAME_ID_EN
    assign bus.frame_id_o = empty ? 8'd0 : id_mem_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_mul8_accum.sv
// tb_mul8_accum: scenario and randomized checks of mul8_accum against a queue-based model.
module tb_mul8_accum;
    localparam int LEN = 4, ACC_W = 16, DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    mul8_accum_if #(.ACC_W(ACC_W), .DEPTH(DEPTH)) bus ();
    mul8_accum #(.LEN(LEN), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    int frame[$];
    int fifo[$];
    int ids[$];
    bit ovf;
    int fid;
    int checks = 0;
    int passes = 0;
    task automatic step(input bit v, input int p, input bit c, input bit r);
        bit pop;
        int s;
        bus.valid_i = v;
        bus.p_i     = 8'(p);
        bus.clr_i   = c;
        bus.ready_i = r;
        @(posedge clk);
        s = -1;
        if (rst) begin
            frame.delete(); fifo.delete(); ids.delete(); ovf = 0; fid = 0;
        end else begin
            pop = fifo.size() > 0 && r;
            if (c) frame.delete();
            else if (v) begin
                frame.push_back(p);
                if (frame.size() == LEN) begin
                    s = frame.sum();
                    frame.delete();
                end
            end
            if (pop) begin
                void'(fifo.pop_front());
                void'(ids.pop_front());
            end
            if (s >= 0) begin
                if (fifo.size() < DEPTH) begin
                    fifo.push_back(s);
                    ids.push_back(fid);
                end else ovf = 1;
                fid = (fid + 1) % 256;
            end
        end
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask
    task automatic test_reset();
        step(1, 7, 0, 0);
        do_reset();
        checks++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid_o); else passes++;
        checks++; if (bus.sum_o !== 16'd0) $display("FAIL reset_sum got %0d want 0", bus.sum_o); else passes++;
        checks++; if (bus.level_o !== 3'd0) $display("FAIL reset_level got %0d want 0", bus.level_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else passes++;
        checks++; if (bus.overflow_o !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow_o); else passes++;
    endtask
    task automatic test_single_frame();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1, i, 0, 1);
            checks++; if (bus.valid_o !== (i == 4)) $display("FAIL single_valid beat %0d got %b want %b", i, bus.valid_o, i == 4); else passes++;
        end
        checks++; if (bus.sum_o !== 16'd10) $display("FAIL single_sum got %0d want 10", bus.sum_o); else passes++;
        checks++; if (bus.level_o !== 3'd1) $display("FAIL single_level got %0d want 1", bus.level_o); else passes++;
        step(0, 0, 0, 1);
        checks++; if (bus.valid_o !== 1'b0) $display("FAIL single_valid_after got %b want 0", bus.valid_o); else passes++;
        checks++; if (bus.level_o !== 3'd0) $display("FAIL single_level_after got %0d want 0", bus.level_o); else passes++;
    endtask
    task automatic test_max_values();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 255, 0, 0);
        checks++; if (bus.sum_o !== 16'h03FC) $display("FAIL max_sum got %0d want 1020", bus.sum_o); else passes++;
        checks++; if (bus.valid_o !== 1'b1) $display("FAIL max_valid got %b want 1", bus.valid_o); else passes++;
    endtask
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
        checks++; if (bus.level_o !== 3'd4) $display("FAIL ovf_level got %0d want 4", bus.level_o); else passes++;
        checks++; if (bus.overflow_o !== 1'b1) $display("FAIL ovf_flag got %b want 1", bus.overflow_o); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.sum_o !== 16'd4 || bus.valid_o !== 1'b1) $display("FAIL ovf_pop%0d got sum %0d valid %b want 4 1", i, bus.sum_o, bus.valid_o); else passes++;
            step(0, 0, 0, 1);
        end
        checks++; if (bus.valid_o !== 1'b0) $display("FAIL ovf_drained_valid got %b want 0", bus.valid_o); else passes++;
        checks++; if (bus.level_o !== 3'd0) $display("FAIL ovf_drained_level got %0d want 0", bus.level_o); else passes++;
        checks++; if (bus.overflow_o !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.overflow_o); else passes++;
    endtask
    task automatic test_gaps();
        int vs[7] = '{1, 0, 0, 1, 1, 0, 1};
        int ps[7] = '{5, 0, 0, 6, 7, 0, 8};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(vs[i] != 0, ps[i], 0, 0);
            checks++; if (bus.busy_o !== (i < 6)) $display("FAIL gap_busy step %0d got %b want %b", i, bus.busy_o, i < 6); else passes++;
        end
        checks++; if (bus.sum_o !== 16'd26 || bus.valid_o !== 1'b1) $display("FAIL gap_sum got %0d valid %b want 26 1", bus.sum_o, bus.valid_o); else passes++;
    endtask
    task automatic test_clear();
        do_reset();
        step(1, 10, 0, 0);
        step(1, 20, 0, 0);
        step(1, 99, 1, 0);
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL clr_busy got %b want 0", bus.busy_o); else passes++;
        checks++; if (bus.valid_o !== 1'b0) $display("FAIL clr_valid got %b want 0", bus.valid_o); else passes++;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        checks++; if (bus.sum_o !== 16'd4) $display("FAIL clr_sum got %0d want 4", bus.sum_o); else passes++;
        checks++; if (bus.level_o !== 3'd1) $display("FAIL clr_level got %0d want 1", bus.level_o); else passes++;
`ifdef MUL8_ACC_FRAME_ID_EN
        checks++; if (bus.frame_id_o !== 8'd0) $display("FAIL clr_id got %0d want 0", bus.frame_id_o); else passes++;
`endif
    endtask
    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 3, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 9, 0, 0);
        step(1, 9, 0, 0);
        checks++; if (bus.level_o !== 3'd2 || bus.busy_o !== 1'b1) $display("FAIL mid_pre got level %0d busy %b want 2 1", bus.level_o, bus.busy_o); else passes++;
        do_reset();
        checks++; if (bus.valid_o !== 1'b0) $display("FAIL mid_valid got %b want 0", bus.valid_o); else passes++;
        checks++; if (bus.level_o !== 3'd0) $display("FAIL mid_level got %0d want 0", bus.level_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL mid_busy got %b want 0", bus.busy_o); else passes++;
        checks++; if (bus.overflow_o !== 1'b0) $display("FAIL mid_ovf got %b want 0", bus.overflow_o); else passes++;
        for (int i = 0; i < 4; i++) step(1, 2, 0, 0);
        checks++; if (bus.sum_o !== 16'd8 || bus.level_o !== 3'd1) $display("FAIL mid_next got sum %0d level %0d want 8 1", bus.sum_o, bus.level_o); else passes++;
    endtask
    task automatic test_random();
        int es;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 24) == 0,
                 i < 300 ? $urandom_range(0, 9) < 3 : $urandom_range(0, 9) < 8);
            es = fifo.size() != 0 ? fifo[0] : 0;
            checks++; if (bus.valid_o !== (fifo.size() != 0)) $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.valid_o, fifo.size() != 0); else passes++;
            checks++; if (bus.sum_o !== 16'(es)) $display("FAIL rnd_sum cyc %0d got %0d want %0d", i, bus.sum_o, es); else passes++;
            checks++; if (bus.level_o !== 3'(fifo.size())) $display("FAIL rnd_level cyc %0d got %0d want %0d", i, bus.level_o, fifo.size()); else passes++;
            checks++; if (bus.busy_o !== (frame.size() != 0)) $display("FAIL rnd_busy cyc %0d got %b want %b", i, bus.busy_o, frame.size() != 0); else passes++;
            checks++; if (bus.overflow_o !== ovf) $display("FAIL rnd_ovf cyc %0d got %b want %b", i, bus.overflow_o, ovf); else passes++;
`ifdef MUL8_ACC_FRAME_ID_EN
            checks++; if (bus.frame_id_o !== 8'(ids.size() != 0 ? ids[0] : 0)) $display("FAIL rnd_id cyc %0d got %0d want %0d", i, bus.frame_id_o, ids.size() != 0 ? ids[0] : 0); else passes++;
`endif
        end
    endtask
    initial begin
        bus.valid_i = 1'b0;
        bus.p_i     = 8'd0;
        bus.clr_i   = 1'b0;
        bus.ready_i = 1'b0;
        do_reset();
        test_reset();
        test_single_frame();
        test_max_values();
        test_overflow();
        test_gaps();
        test_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
